// File: rtl/goc_pwm_tx.sv
// GOC downstream serializer: pops bytes from a FWFT FIFO and sends them MSB-first
// as a 4-unit-per-bit PWM stream ('1' = 3 high + 1 low, '0' = 1 high + 3 low).
module goc_pwm_tx #(
    parameter int CNT_W     = 22,
    parameter int BIT_UNITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       fifo_din,
    input  logic             fifo_empty,
    output logic             fifo_re,
    input  logic             start_tx,
    input  logic [CNT_W-1:0] base_counter,
    output logic             pwm_out,
    output logic             busy,
    output logic             byte_done
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] ulen_q, ulen_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       ucnt_q, ucnt_d;
    logic             pwm_q, pwm_d;
    logic             done_q, done_d;
    logic             re_c;

    logic       load_ok;
    logic [1:0] long_units, phase_units;
    logic       unit_end, phase_end;

    assign load_ok    = start_tx & ~fifo_empty;
    assign long_units = 2'(BIT_UNITS - 1);
    // A '1' spends the long phase high; a '0' spends it low.
    assign phase_units = (state_q == HIGH) ? (shift_q[7] ? long_units : 2'd1)
                                           : (shift_q[7] ? 2'd1 : long_units);
    assign unit_end  = (timer_q == '0);
    assign phase_end = unit_end && (ucnt_q == phase_units - 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ulen_q    <= '0;
            timer_q   <= '0;
            ucnt_q    <= '0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ulen_q    <= ulen_d;
            timer_q   <= timer_d;
            ucnt_q    <= ucnt_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ulen_d    = ulen_q;
        timer_d   = timer_q;
        ucnt_d    = ucnt_q;
        done_d    = 1'b0;
        re_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_ok) begin
                    re_c      = 1'b1;
                    shift_d   = fifo_din;
                    bit_cnt_d = 3'd7;
                    ulen_d    = base_counter;
                    timer_d   = base_counter;
                    ucnt_d    = '0;
                    state_d   = HIGH;
                end
            end
            HIGH, LOW: begin
                if (!unit_end) begin
                    timer_d = timer_q - 1'b1;
                end else if (!phase_end) begin
                    timer_d = ulen_q;
                    ucnt_d  = ucnt_q + 2'd1;
                end else begin
                    timer_d = ulen_q;
                    ucnt_d  = '0;
                    if (state_q == HIGH) begin
                        state_d = LOW;
                    end else if (bit_cnt_q != '0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        state_d   = HIGH;
                    end else begin
                        // Final unit of the byte: chain straight into the next one if possible.
                        done_d = 1'b1;
                        if (load_ok) begin
                            re_c      = 1'b1;
                            shift_d   = fifo_din;
                            bit_cnt_d = 3'd7;
                            ulen_d    = base_counter;
                            timer_d   = base_counter;
                            state_d   = HIGH;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        pwm_d = (state_d == HIGH);
    end

    assign fifo_re   = re_c & ~reset;
    assign pwm_out   = pwm_q;
    assign busy      = (state_q != IDLE);
    assign byte_done = done_q;

endmodule

// File: tb/tb_goc_pwm_tx.sv
// Scoreboard bench for goc_pwm_tx: a FIFO model pushes the expected PWM stream of each
// popped byte; a monitor compares pwm_out every busy cycle.
module tb_goc_pwm_tx;

    localparam int CNT_W = 22;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       fifo_din;
    logic             fifo_empty;
    logic             fifo_re;
    logic             start_tx;
    logic [CNT_W-1:0] base_counter;
    logic             pwm_out;
    logic             busy;
    logic             byte_done;

    goc_pwm_tx #(.CNT_W(CNT_W), .BIT_UNITS(4)) dut (
        .clk(clk), .reset(reset), .fifo_din(fifo_din), .fifo_empty(fifo_empty),
        .fifo_re(fifo_re), .start_tx(start_tx), .base_counter(base_counter),
        .pwm_out(pwm_out), .busy(busy), .byte_done(byte_done)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic       exp_q[$];
    int         pop_cyc[$];
    int         cyc = 0, pops = 0, busy_cnt = 0, done_cnt = 0;
    int         n_pass = 0, n_tot = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_din   = fifo_empty ? 8'h00 : fifo_q[0];
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    // FIFO model: the popped byte's waveform becomes the expected response.
    initial begin
        logic re;
        int   u;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            re = fifo_re;
            u  = int'(base_counter) + 1;
            @(posedge clk);
            cyc++;
            #1;
            if (re) begin
                if (fifo_q.size() == 0) begin
                    chk("pop_from_empty", 1, 0);
                end else begin
                    b = fifo_q.pop_front();
                    pops++;
                    pop_cyc.push_back(cyc);
                    for (int i = 7; i >= 0; i--) begin
                        for (int k = 0; k < 4 * u; k++)
                            exp_q.push_back(k < (b[i] ? 3 : 1) * u);
                    end
                    refresh();
                end
            end
        end
    end

    // Monitor
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (byte_done) done_cnt++;
            if (busy) begin
                busy_cnt++;
                if (exp_q.size() == 0) chk("busy_without_byte", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("pwm_bit", pwm_out, e);
                end
            end else begin
                chk("idle_pwm_low", pwm_out, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name);
        int i;
        tick(3);
        for (i = 0; i < 3000; i++) begin
            if (!busy && exp_q.size() == 0 && (fifo_empty || !start_tx)) break;
            tick(1);
        end
        if (i == 3000) chk({name, "_timeout"}, 1, 0);
        tick(2);
    endtask

    task automatic new_test();
        start_tx = 1'b0;
        tick(2);
        fifo_q.delete();
        refresh();
        pops = 0; busy_cnt = 0; done_cnt = 0;
        pop_cyc.delete();
    endtask

    initial begin
        int c0;
        reset = 1'b1; start_tx = 1'b0; base_counter = '0;
        refresh();
        tick(3);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_re", fifo_re, 0);
        chk("rst_done", byte_done, 0);
        reset = 1'b0;
        tick(1);

        // 1) 0xA5 at U=1
        new_test();
        base_counter = 0;
        push(8'hA5);
        start_tx = 1'b1;
        wait_done("t1");
        chk("t1_pops", pops, 1);
        chk("t1_busy", busy_cnt, 32);
        chk("t1_done", done_cnt, 1);

        // 2) 0xFF,0x00 at U=3, back-to-back
        new_test();
        base_counter = 2;
        push(8'hFF); push(8'h00);
        start_tx = 1'b1;
        wait_done("t2");
        chk("t2_pops", pops, 2);
        chk("t2_busy", busy_cnt, 192);
        chk("t2_done", done_cnt, 2);
        if (pop_cyc.size() == 2) chk("t2_pop_gap", pop_cyc[1] - pop_cyc[0], 96);
        else chk("t2_pop_list", pop_cyc.size(), 2);

        // 3) start_tx dropped mid-byte
        new_test();
        base_counter = 0;
        push(8'h3C); push(8'h11);
        start_tx = 1'b1;
        tick(11);
        start_tx = 1'b0;
        wait_done("t3");
        chk("t3_pops", pops, 1);
        chk("t3_busy", busy_cnt, 32);
        chk("t3_left", fifo_q.size(), 1);
        chk("t3_busy_low", busy, 0);

        // 4) empty FIFO, then data arrives
        new_test();
        base_counter = 0;
        start_tx = 1'b1;
        tick(6);
        chk("t4_no_pop", pops, 0);
        chk("t4_idle_busy", busy, 0);
        c0 = cyc;
        push(8'h80);
        wait_done("t4");
        chk("t4_pops", pops, 1);
        if (pop_cyc.size() == 1) chk("t4_pop_lat", pop_cyc[0] - c0, 1);
        chk("t4_busy", busy_cnt, 32);

        // 5) reset mid-byte
        new_test();
        base_counter = 0;
        push(8'h96); push(8'h0F);
        start_tx = 1'b1;
        tick(12);
        reset = 1'b1;
        tick(1);
        exp_q.delete();
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_pwm", pwm_out, 0);
        reset = 1'b0;
        wait_done("t5");
        chk("t5_pops", pops, 2);
        chk("t5_left", fifo_q.size(), 0);

        // 6) base_counter changed mid-byte
        new_test();
        base_counter = 1;
        push(8'h5A); push(8'hC3);
        start_tx = 1'b1;
        tick(8);
        base_counter = 4;
        wait_done("t6");
        chk("t6_pops", pops, 2);
        chk("t6_busy", busy_cnt, 64 + 160);
        if (pop_cyc.size() == 2) chk("t6_pop_gap", pop_cyc[1] - pop_cyc[0], 64);
        else chk("t6_pop_list", pop_cyc.size(), 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
